// File: rtl/pca_register_sequencer_pkg.sv
// pca_register_sequencer_pkg
//   Shared constants for the PCA register sequencer: register map ids,
//   the FSM state encoding and the power-on default value of every
//   register address.
package pca_register_sequencer_pkg;

    // Register map ids
    localparam logic [7:0] MODE1         = 8'h00;
    localparam logic [7:0] MODE2         = 8'h01;
    localparam logic [7:0] SUBADR1       = 8'h02;
    localparam logic [7:0] SUBADR2       = 8'h03;
    localparam logic [7:0] SUBADR3       = 8'h04;
    localparam logic [7:0] ALLCALLADR    = 8'h05;
    localparam logic [7:0] LED0_ON_L     = 8'h06;
    localparam logic [7:0] LED15_OFF_H   = 8'h45;
    localparam logic [7:0] ALL_LED_ON_L  = 8'hFA;
    localparam logic [7:0] ALL_LED_ON_H  = 8'hFB;
    localparam logic [7:0] ALL_LED_OFF_L = 8'hFC;
    localparam logic [7:0] ALL_LED_OFF_H = 8'hFD;
    localparam logic [7:0] PRE_SCALE     = 8'hFE;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FANOUT = 2'd3
    } seq_state_e;

    // Power-on value of a register address. Each LED owns four registers
    // starting at LED0_ON_L; the OFF_H register of each LED (offset 3,
    // i.e. address bits [1:0] == 2'b01) powers up with the full-off bit set.
    function automatic logic [7:0] reg_default(input logic [7:0] addr);
        logic [7:0] val;
        case (addr)
            MODE1:         val = 8'h11;
            MODE2:         val = 8'h04;
            SUBADR1:       val = 8'hE2;
            SUBADR2:       val = 8'hE4;
            SUBADR3:       val = 8'hE8;
            ALLCALLADR:    val = 8'hE0;
            ALL_LED_OFF_H: val = 8'h10;
            PRE_SCALE:     val = 8'h1E;
            default: begin
                if ((addr > LED0_ON_L) && (addr <= LED15_OFF_H) && (addr[1:0] == 2'b01)) begin
                    val = 8'h10;
                end else begin
                    val = 8'h00;
                end
            end
        endcase
        return val;
    endfunction

endpackage

// File: rtl/pca_register_sequencer_write_fifo.sv
// pca_write_fifo
//   Synchronous first-word-fall-through FIFO holding {id, value} write
//   requests. A push into a full FIFO is accepted only when a pop happens
//   in the same cycle. flush empties the FIFO synchronously.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of all entries
//   push, wdata     write side
//   pop, rdata      read side (rdata shows the head entry)
//   full, empty     occupancy flags
module pca_write_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {CW{1'b0}});
    assign rdata     = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pca_register_sequencer.sv
// pca_register_sequencer
//   Sole owner of the write port of the 256x8 PCA register store. Loads
//   power-on defaults after reset or soft reset, buffers write requests
//   from the I2C target and (optionally) fans ALL_LED_* writes out to the
//   LEDn registers.
// Configuration macro
//   PCA_ALL_LED_FANOUT_EN  defined: ALL_LED_* writes are followed by one
//                          write per LED channel; undefined: they are
//                          plain single writes and no fan-out logic exists.
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   soft_rst_ni            synchronous low pulse: flush and restart INIT
//   wr_id_i, wr_value_i    request id / value, sampled on wr_en_i rise
//   wr_en_i                request level, a request is its rising edge
//   reg_addr_o/data_o/we_o register store write port (registered)
//   init_busy_o            high while defaults are being loaded
//   overflow_o             sticky, a request was dropped
module pca_register_sequencer
    import pca_register_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NUM_LEDS   = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       soft_rst_ni,
    input  logic [7:0] wr_id_i,
    input  logic [7:0] wr_value_i,
    input  logic       wr_en_i,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_data_o,
    output logic       reg_we_o,
    output logic       init_busy_o,
    output logic       overflow_o
);
    // Elaboration-time parameter sanity
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if ((NUM_LEDS < 2) || (NUM_LEDS > 16)) begin : g_bad_leds
        $error("NUM_LEDS must be in 2..16");
    end

    seq_state_e  state_r;
    seq_state_e  state_nx_s;
    logic [7:0]  init_idx_r;
    logic [7:0]  init_idx_nx_s;
    logic        wr_en_q_r;
    logic        edge_s;
    logic        push_s;
    logic        drop_s;
    logic        pop_s;
    logic [15:0] head_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        we_s;
    logic [7:0]  addr_s;
    logic [7:0]  data_s;
    logic        reg_we_r;
    logic [7:0]  reg_addr_r;
    logic [7:0]  reg_data_r;
    logic        busy_r;
    logic        overflow_r;

`ifdef PCA_ALL_LED_FANOUT_EN
    localparam int unsigned FIW = $clog2(NUM_LEDS);
    localparam logic [FIW-1:0] FAN_LAST = FIW'(NUM_LEDS - 1);
    localparam logic [FIW-1:0] FAN_ONE  = FIW'(1);

    logic [FIW-1:0] fan_idx_r;
    logic [FIW-1:0] fan_idx_nx_s;
    logic [1:0]     fan_off_r;
    logic [1:0]     fan_off_nx_s;
    logic [7:0]     fan_val_r;
    logic [7:0]     fan_val_nx_s;
    logic           is_all_led_s;

    assign is_all_led_s = (head_s[15:8] >= ALL_LED_ON_L) && (head_s[15:8] <= ALL_LED_OFF_H);
`endif

    // A request is the rising edge of wr_en_i; it is only queued outside
    // INIT, and a full FIFO still accepts it when the head leaves this cycle.
    assign edge_s = wr_en_i & ~wr_en_q_r;
    assign push_s = edge_s & soft_rst_ni & (state_r != ST_INIT) & (~fifo_full_s | pop_s);
    assign drop_s = edge_s & soft_rst_ni & ~push_s;

    pca_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .flush (~soft_rst_ni),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({wr_id_i, wr_value_i}),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next state and the write to present on the store port next cycle
    always_comb begin
        state_nx_s    = state_r;
        init_idx_nx_s = init_idx_r;
        pop_s         = 1'b0;
        we_s          = 1'b0;
        addr_s        = 8'h00;
        data_s        = 8'h00;
`ifdef PCA_ALL_LED_FANOUT_EN
        fan_idx_nx_s  = fan_idx_r;
        fan_off_nx_s  = fan_off_r;
        fan_val_nx_s  = fan_val_r;
`endif
        if (!soft_rst_ni) begin
            // Abort whatever is running; the already-registered write completes.
            state_nx_s    = ST_INIT;
            init_idx_nx_s = 8'h00;
        end else begin
            case (state_r)
                ST_INIT: begin
                    we_s   = 1'b1;
                    addr_s = init_idx_r;
                    data_s = reg_default(init_idx_r);
                    if (init_idx_r == 8'hFF) begin
                        state_nx_s    = ST_IDLE;
                        init_idx_nx_s = 8'h00;
                    end else begin
                        init_idx_nx_s = init_idx_r + 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        pop_s  = 1'b1;
                        we_s   = 1'b1;
                        addr_s = head_s[15:8];
                        data_s = head_s[7:0];
`ifdef PCA_ALL_LED_FANOUT_EN
                        if (is_all_led_s) begin
                            state_nx_s   = ST_FANOUT;
                            fan_idx_nx_s = {FIW{1'b0}};
                            // Register offset within each LED block (ON_L..OFF_H)
                            fan_off_nx_s = head_s[9:8] - ALL_LED_ON_L[1:0];
                            fan_val_nx_s = head_s[7:0];
                        end else begin
                            state_nx_s = ST_WRITE;
                        end
`else
                        state_nx_s = ST_WRITE;
`endif
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state_nx_s = ST_IDLE;
                end
`ifdef PCA_ALL_LED_FANOUT_EN
                ST_FANOUT: begin
                    we_s   = 1'b1;
                    addr_s = LED0_ON_L + 8'({fan_idx_r, 2'b00}) + 8'(fan_off_r);
                    data_s = fan_val_r;
                    if (fan_idx_r == FAN_LAST) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        fan_idx_nx_s = fan_idx_r + FAN_ONE;
                    end
                end
`endif
                default: begin
                    state_nx_s    = ST_INIT;
                    init_idx_nx_s = 8'h00;
                end
            endcase
        end
    end

    // FSM state, counters and request edge detector
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_INIT;
            init_idx_r <= 8'h00;
            wr_en_q_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            init_idx_r <= init_idx_nx_s;
            wr_en_q_r  <= wr_en_i;
        end
    end

`ifdef PCA_ALL_LED_FANOUT_EN
    // Fan-out channel index and captured ALL_LED request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fan_idx_r <= {FIW{1'b0}};
            fan_off_r <= 2'b00;
            fan_val_r <= 8'h00;
        end else begin
            fan_idx_r <= fan_idx_nx_s;
            fan_off_r <= fan_off_nx_s;
            fan_val_r <= fan_val_nx_s;
        end
    end
`endif

    // Registered store write port and status flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_we_r   <= 1'b0;
            reg_addr_r <= 8'h00;
            reg_data_r <= 8'h00;
            busy_r     <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            reg_we_r   <= we_s;
            reg_addr_r <= addr_s;
            reg_data_r <= data_s;
            // Stays high through the cycle that shows the last default write
            busy_r     <= (state_nx_s == ST_INIT) | (state_r == ST_INIT);
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign reg_we_o    = reg_we_r;
    assign reg_addr_o  = reg_addr_r;
    assign reg_data_o  = reg_data_r;
    assign init_busy_o = busy_r;
    assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_pca_register_sequencer.sv
// tb_pca_register_sequencer
//   Directed bench for pca_register_sequencer. A monitor logs every store
//   write with its cycle number; each scenario then compares the log with
//   hand-derived expectations. Build-dependent scenarios follow
//   PCA_ALL_LED_FANOUT_EN.
module tb_pca_register_sequencer;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       soft_rst_ni;
    logic [7:0] wr_id_i;
    logic [7:0] wr_value_i;
    logic       wr_en_i;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_data_o;
    logic       reg_we_o;
    logic       init_busy_o;
    logic       overflow_o;

    pca_register_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .soft_rst_ni (soft_rst_ni),
        .wr_id_i     (wr_id_i),
        .wr_value_i  (wr_value_i),
        .wr_en_i     (wr_en_i),
        .reg_addr_o  (reg_addr_o),
        .reg_data_o  (reg_data_o),
        .reg_we_o    (reg_we_o),
        .init_busy_o (init_busy_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;
    wr_t log_q[$];

    always @(negedge clk) begin
        wr_t e;
        if (rst_ni === 1'b1 && reg_we_o === 1'b1) begin
            e.a = reg_addr_o;
            e.d = reg_data_o;
            e.c = cyc;
            log_q.push_back(e);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] id, input logic [7:0] val);
        wr_id_i    = id;
        wr_value_i = val;
        wr_en_i    = 1'b1;
        step(1);
        wr_en_i    = 1'b0;
        step(1);
    endtask

    task automatic wait_init_done(input int bound);
        int k = 0;
        while (init_busy_o !== 1'b0 && k < bound) begin
            step(1);
            k++;
        end
        chk("init_done", {31'd0, init_busy_o}, 32'd0);
    endtask

    // Power-on value table of the register map
    function automatic logic [7:0] dflt(input int a);
        case (a)
            8'h00:   return 8'h11;
            8'h01:   return 8'h04;
            8'h02:   return 8'hE2;
            8'h03:   return 8'hE4;
            8'h04:   return 8'hE8;
            8'h05:   return 8'hE0;
            8'hFD:   return 8'h10;
            8'hFE:   return 8'h1E;
            default: return ((a >= 9) && (a <= 69) && ((a % 4) == 1)) ? 8'h10 : 8'h00;
        endcase
    endfunction

    // Checks 256 consecutive default writes starting at log index 'first'
    task automatic check_init_log(input string tag, input int first, input int start_cyc);
        int errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (log_q[first+i].a != 8'(i) || log_q[first+i].d != dflt(i) ||
                log_q[first+i].c != start_cyc + i) errs++;
        end
        chk(tag, errs, 0);
    endtask

    initial begin
        int c0;
        int sc;
        int pre;
        int errs;
        logic [7:0] pre_a [5];

        rst_ni      = 1'b0;
        soft_rst_ni = 1'b1;
        wr_en_i     = 1'b0;
        wr_id_i     = 8'h00;
        wr_value_i  = 8'h00;
        step(3);

        // Reset state
        chk("rst_we",   {31'd0, reg_we_o},    32'd0);
        chk("rst_addr", {24'd0, reg_addr_o},  32'd0);
        chk("rst_data", {24'd0, reg_data_o},  32'd0);
        chk("rst_busy", {31'd0, init_busy_o}, 32'd1);
        chk("rst_ovf",  {31'd0, overflow_o},  32'd0);

        // Power-on INIT: 256 writes, addr 0..255, default data
        log_q.delete();
        c0 = cyc;
        rst_ni = 1'b1;
        wait_init_done(400);
        step(2);
        chk("init_count", log_q.size(), 256);
        if (log_q.size() == 256) begin
            chk("init_00", {24'd0, log_q[0].d},   32'h11);
            chk("init_01", {24'd0, log_q[1].d},   32'h04);
            chk("init_09", {24'd0, log_q[9].d},   32'h10);
            chk("init_45", {24'd0, log_q[69].d},  32'h10);
            chk("init_08", {24'd0, log_q[8].d},   32'h00);
            chk("init_FE", {24'd0, log_q[254].d}, 32'h1E);
            chk("init_FF", {24'd0, log_q[255].d}, 32'h00);
            check_init_log("init_all", 0, c0 + 1);
        end

        // Level held high 50 cycles: one write, two cycles after the edge
        step(3);
        log_q.delete();
        c0 = cyc;
        wr_id_i    = 8'h06;
        wr_value_i = 8'h55;
        wr_en_i    = 1'b1;
        step(50);
        wr_en_i = 1'b0;
        step(5);
        chk("hold_count", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("hold_addr",    {24'd0, log_q[0].a}, 32'h06);
            chk("hold_data",    {24'd0, log_q[0].d}, 32'h55);
            chk("hold_latency", log_q[0].c,          c0 + 2);
        end
        chk("hold_ovf", {31'd0, overflow_o}, 32'd0);

        // ALL_LED_OFF_H <- 0x10
        log_q.delete();
        c0 = cyc;
        pulse(8'hFD, 8'h10);
        step(25);
`ifdef PCA_ALL_LED_FANOUT_EN
        chk("fan_count", log_q.size(), 17);
        if (log_q.size() == 17) begin
            errs = 0;
            for (int i = 0; i < 17; i++) begin
                if (log_q[i].a != ((i == 0) ? 8'hFD : 8'(9 + 4 * (i - 1)))) errs++;
                if (log_q[i].d != 8'h10) errs++;
                if (log_q[i].c != c0 + 2 + i) errs++;
            end
            chk("fan_seq",  errs, 0);
            chk("fan_last", {24'd0, log_q[16].a}, 32'h45);
        end

        // Six edges during one fan-out: four queued in order, two dropped
        chk("six_ovf_before", {31'd0, overflow_o}, 32'd0);
        log_q.delete();
        pulse(8'hFA, 8'h33);
        for (int k = 0; k < 6; k++) pulse(8'(8'h10 + k), 8'(8'hA0 + k));
        step(30);
        chk("six_count", log_q.size(), 21);
        if (log_q.size() == 21) begin
            errs = 0;
            for (int i = 0; i < 17; i++) begin
                if (log_q[i].a != ((i == 0) ? 8'hFA : 8'(6 + 4 * (i - 1)))) errs++;
                if (log_q[i].d != 8'h33) errs++;
            end
            chk("six_fan", errs, 0);
            errs = 0;
            for (int k = 0; k < 4; k++) begin
                if (log_q[17+k].a != 8'(8'h10 + k) || log_q[17+k].d != 8'(8'hA0 + k)) errs++;
            end
            chk("six_queued", errs, 0);
        end
        chk("six_ovf_after", {31'd0, overflow_o}, 32'd1);

        // Soft reset in the middle of a fan-out with two queued requests
        log_q.delete();
        c0 = cyc;
        pulse(8'hFA, 8'h77);
        pulse(8'h20, 8'hB0);
        pulse(8'h21, 8'hB1);
        soft_rst_ni = 1'b0;
        sc = cyc;
        step(1);
        soft_rst_ni = 1'b1;
        pre = 5;
        pre_a[0] = 8'hFA; pre_a[1] = 8'h06; pre_a[2] = 8'h0A; pre_a[3] = 8'h0E; pre_a[4] = 8'h12;
        chk("srst_ovf_kept", {31'd0, overflow_o}, 32'd1);
`else
        chk("single_count", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("single_addr", {24'd0, log_q[0].a}, 32'hFD);
            chk("single_data", {24'd0, log_q[0].d}, 32'h10);
        end

        // Soft reset while one request waits in the FIFO
        log_q.delete();
        c0 = cyc;
        wr_id_i     = 8'h20;
        wr_value_i  = 8'hB0;
        wr_en_i     = 1'b1;
        step(1);
        wr_en_i     = 1'b0;
        soft_rst_ni = 1'b0;
        sc = cyc;
        step(1);
        soft_rst_ni = 1'b1;
        pre = 0;
        for (int i = 0; i < 5; i++) pre_a[i] = 8'h00;
        chk("srst_ovf_clear", {31'd0, overflow_o}, 32'd0);
`endif
        chk("srst_busy", {31'd0, init_busy_o}, 32'd1);
        // Request during INIT is dropped and flagged
        pulse(8'h30, 8'hC0);
        wait_init_done(400);
        step(10);
        chk("srst_ovf_init", {31'd0, overflow_o}, 32'd1);
        chk("srst_count", log_q.size(), pre + 256);
        if (log_q.size() == pre + 256) begin
            errs = 0;
            for (int i = 0; i < pre; i++) begin
                if (log_q[i].a != pre_a[i] || log_q[i].d != 8'h77) errs++;
            end
            chk("srst_pre", errs, 0);
            chk("srst_first_addr", {24'd0, log_q[pre].a}, 32'h00);
            chk("srst_first_cyc",  log_q[pre].c, sc + 2);
            check_init_log("srst_init", pre, sc + 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
